// File: rtl/acondicionador_botones_if.sv
// rtl/acondicionador_botones_if.sv - raw button inputs and conditioned event outputs
// master drives the raw buttons; slave is the conditioner.
interface acondicionador_botones_if;
  logic boton_comida_raw;
  logic boton_medicina_raw;
  logic pulso_comida;
  logic pulso_medicina;
  logic largo_comida;
  logic largo_medicina;
  logic nivel_comida;
  logic nivel_medicina;

  modport master (
    output boton_comida_raw,
    output boton_medicina_raw,
    input  pulso_comida,
    input  pulso_medicina,
    input  largo_comida,
    input  largo_medicina,
    input  nivel_comida,
    input  nivel_medicina
  );

  modport slave (
    input  boton_comida_raw,
    input  boton_medicina_raw,
    output pulso_comida,
    output pulso_medicina,
    output largo_comida,
    output largo_medicina,
    output nivel_comida,
    output nivel_medicina
  );
endinterface

// File: rtl/acondicionador_botones.sv
// rtl/acondicionador_botones.sv - two-channel synchronize, debounce, press and long-press pulses
// Channel 0 is food, channel 1 is medicine; the channels share no state.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 250
) (
  input logic                     clk,
  input logic                     reset,
  acondicionador_botones_if.slave bus
);
  localparam int RW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [RW-1:0] REB_MAX    = RW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LARGO_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LARGO_PREV = LW'(LONG_CYCLES - 1);

  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    estable;
  logic [1:0]    pulso;
  logic [1:0]    largo;
  logic [RW-1:0] cnt_reb   [2];
  logic [LW-1:0] cnt_largo [2];

  assign raw = {bus.boton_medicina_raw, bus.boton_comida_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      estable <= '0;
      pulso   <= '0;
      largo   <= '0;
      for (int c = 0; c < 2; c++) begin
        cnt_reb[c]   <= '0;
        cnt_largo[c] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int c = 0; c < 2; c++) begin
        pulso[c] <= 1'b0;
        largo[c] <= 1'b0;

        // Any sample agreeing with the stable level restarts the debounce window.
        if (s2[c] == estable[c]) begin
          cnt_reb[c] <= '0;
        end else if (cnt_reb[c] == REB_MAX) begin
          estable[c] <= s2[c];
          cnt_reb[c] <= '0;
          pulso[c]   <= s2[c];
        end else begin
          cnt_reb[c] <= cnt_reb[c] + RW'(1);
        end

        // Old level 0 also covers the rising edge, so each press starts from zero.
        if (!estable[c]) begin
          cnt_largo[c] <= '0;
        end else if (cnt_largo[c] != LARGO_MAX) begin
          cnt_largo[c] <= cnt_largo[c] + LW'(1);
          largo[c]     <= (cnt_largo[c] == LARGO_PREV);
        end
      end
    end
  end

  assign bus.pulso_comida   = pulso[0];
  assign bus.pulso_medicina = pulso[1];
  assign bus.largo_comida   = largo[0];
  assign bus.largo_medicina = largo[1];
  assign bus.nivel_comida   = estable[0];
  assign bus.nivel_medicina = estable[1];
endmodule

// File: tb/tb_acondicionador_botones.sv
// tb/tb_acondicionador_botones.sv - directed checks of the button conditioner
// Output vector order: pulso_c pulso_m largo_c largo_m nivel_c nivel_m.
module tb_acondicionador_botones;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  acondicionador_botones_if bus ();

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #1 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.pulso_comida, bus.pulso_medicina, bus.largo_comida,
            bus.largo_medicina, bus.nivel_comida, bus.nivel_medicina};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    bus.boton_comida_raw   = 1'b0;
    bus.boton_medicina_raw = 1'b0;
    tick();
    tick();
    got = outs();
    vectors++;
    if (got !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_state got %b expected %b", got, 6'b000000);
    end
    reset = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      got = outs();
      vectors++;
      if (got !== 6'b000000) begin
        miscompares++;
        $display("FAIL idle cycle %0d got %b expected %b", i, got, 6'b000000);
      end
    end
  endtask

  task automatic test_short_press();
    logic [5:0] got, exp;
    bus.boton_comida_raw = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      got = outs();
      exp = {i == 6, 1'b0, 1'b0, 1'b0, i >= 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL short_press cycle %0d got %b expected %b", i, got, exp);
      end
    end
    bus.boton_comida_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, i < 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL short_release cycle %0d got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      bus.boton_medicina_raw = ((i / 2) % 2) == 0;
      tick();
      got = outs();
      vectors++;
      if (got !== 6'b000000) begin
        miscompares++;
        $display("FAIL bounce cycle %0d got %b expected %b", i, got, 6'b000000);
      end
    end
    bus.boton_medicina_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {1'b0, i == 6, 1'b0, 1'b0, 1'b0, i >= 6};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bounce_settle cycle %0d got %b expected %b", i, got, exp);
      end
    end
    bus.boton_medicina_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i < 6};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bounce_release cycle %0d got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [5:0] got, exp;
    bus.boton_comida_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      got = outs();
      exp = {i == 6, 1'b0, i == 26, 1'b0, i >= 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL long_hold cycle %0d got %b expected %b", i, got, exp);
      end
    end
    bus.boton_comida_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, i < 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL long_release cycle %0d got %b expected %b", i, got, exp);
      end
    end
    bus.boton_comida_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {i == 6, 1'b0, 1'b0, 1'b0, i >= 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL second_press cycle %0d got %b expected %b", i, got, exp);
      end
    end
    bus.boton_comida_raw = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      got = outs();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, i < 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL second_release cycle %0d got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] got, exp;
    bus.boton_comida_raw   = 1'b1;
    bus.boton_medicina_raw = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      got = outs();
      exp = {i == 6, i == 6, i == 26, 1'b0, i >= 6, (i >= 6) && (i < 16)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL simultaneous cycle %0d got %b expected %b", i, got, exp);
      end
      if (i == 10) bus.boton_medicina_raw = 1'b0;
    end
    bus.boton_comida_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = outs();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, i < 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL simultaneous_release cycle %0d got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [5:0] got, exp;
    bus.boton_comida_raw = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    got = outs();
    vectors++;
    if (got !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_mid_debounce got %b expected %b", got, 6'b000000);
    end
    reset = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      got = outs();
      exp = {i == 6, 1'b0, 1'b0, 1'b0, i >= 6, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL held_through_reset cycle %0d got %b expected %b", i, got, exp);
      end
    end
    // The long pulse would be due on the 26th edge; reset covers edges 25 and 26.
    reset = 1'b1;
    for (int i = 25; i <= 26; i++) begin
      tick();
      got = outs();
      vectors++;
      if (got !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_before_largo cycle %0d got %b expected %b", i, got, 6'b000000);
      end
    end
    bus.boton_comida_raw = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      got = outs();
      vectors++;
      if (got !== 6'b000000) begin
        miscompares++;
        $display("FAIL after_abort cycle %0d got %b expected %b", i, got, 6'b000000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
